// File: rtl/exec_pkg.sv
// ----------------------------------------------------------------------------
// exec_pkg
// Shared types and constants for the CPU execute stage.
//   op_t    : operation codes carried on the op bus (codes 12..15 are unused)
//   state_t : execute-stage sequencer states
//   FLAG_*  : bit positions inside the {N,Z,C,V} flags word
// ----------------------------------------------------------------------------
package exec_pkg;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        AND = 4'd2,
        OR  = 4'd3,
        XOR = 4'd4,
        NOT = 4'd5,
        MOV = 4'd6,
        CMP = 4'd7,
        SHL = 4'd8,
        SHR = 4'd9,
        SAR = 4'd10,
        MUL = 4'd11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cpu_execute_if.sv
// ----------------------------------------------------------------------------
// cpu_execute_if
// Bundle between the register-read stage, the execute stage and the
// register-file write port.
//   issue side : in_valid, in_ready, op, a, b, dst, wb_en, flush
//   result side: we, src_w, val, done, flags
// master = upstream/test driver, slave = cpu_execute.
// ----------------------------------------------------------------------------
interface cpu_execute_if #(
    parameter int WIDTH    = 16,
    parameter int REG_BITS = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [3:0]          op;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic [REG_BITS-1:0] dst;
    logic                wb_en;
    logic                flush;
    logic                we;
    logic [REG_BITS-1:0] src_w;
    logic [WIDTH-1:0]    val;
    logic                done;
    logic [3:0]          flags;

    modport master (
        output in_valid, op, a, b, dst, wb_en, flush,
        input  in_ready, we, src_w, val, done, flags
    );

    modport slave (
        input  in_valid, op, a, b, dst, wb_en, flush,
        output in_ready, we, src_w, val, done, flags
    );
endinterface

// File: rtl/cpu_alu.sv
// ----------------------------------------------------------------------------
// cpu_alu
// Purely combinational single-cycle operations and their flags.
//   op       : operation code
//   a, b     : operands
//   result   : operation result
//   flags    : {N,Z,C,V} for this result
//   known    : op completes in one cycle here and updates flags
//   writes   : result may be written to the register file (not CMP)
// Shifts arrive here only with a zero count, so they pass a through.
// ----------------------------------------------------------------------------
module cpu_alu
    import exec_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             known,
    output logic             writes
);
    logic [WIDTH:0] sum;
    logic           c;
    logic           v;

    always_comb begin
        sum    = '0;
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        known  = 1'b1;
        writes = 1'b1;
        case (op)
            ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[WIDTH-1:0];
                c      = sum[WIDTH];
                v      = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            SUB, CMP: begin
                // a + ~b + 1: carry set means no borrow (a >= b unsigned)
                sum    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                result = sum[WIDTH-1:0];
                c      = sum[WIDTH];
                v      = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
                writes = (op != CMP);
            end
            AND:           result = a & b;
            OR:            result = a | b;
            XOR:           result = a ^ b;
            NOT:           result = ~a;
            MOV:           result = b;
            SHL, SHR, SAR: result = a;
            default: begin
                known  = 1'b0;
                writes = 1'b0;
            end
        endcase
        flags         = '0;
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = c;
        flags[FLAG_V] = v;
    end
endmodule

// File: rtl/cpu_execute.sv
// ----------------------------------------------------------------------------
// cpu_execute
// Execute stage: single-cycle ALU ops via cpu_alu, bit-serial shifts (one bit
// per cycle) and a 16-step shift-add multiply. Drives the register-file
// write port and the {N,Z,C,V} flags register.
//   cpu_clk : clock, rising edge
//   cpu_rst : asynchronous active-low reset
//   bus     : cpu_execute_if slave (issue handshake, operands, result port)
// in_ready is high only while idle, so upstream stalls during shift/MUL.
// ----------------------------------------------------------------------------
module cpu_execute
    import exec_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int REG_BITS = 4
) (
    input  logic         cpu_clk,
    input  logic         cpu_rst,
    cpu_execute_if.slave bus
);
    state_t              state_reg, state_next;
    logic [3:0]          op_reg;
    logic [REG_BITS-1:0] dst_reg;
    logic                wb_en_reg;
    logic [4:0]          cnt_reg;
    logic [WIDTH-1:0]    work_reg;    // shift value, or multiplier for MUL
    logic [WIDTH-1:0]    mcand_reg;
    logic [WIDTH-1:0]    acc_reg;
    logic                we_reg, done_reg;
    logic [REG_BITS-1:0] src_w_reg;
    logic [WIDTH-1:0]    val_reg;
    logic [3:0]          flags_reg;

    logic [WIDTH-1:0]    alu_result;
    logic [3:0]          alu_flags;
    logic                alu_known, alu_writes;

    logic                accept, is_shift, start_shift, start_mul;
    logic [WIDTH-1:0]    shift_val, mul_acc, fin_res;
    logic                shift_c, fin_c, step_last;

    cpu_alu #(.WIDTH(WIDTH)) u_alu (
        .op     (bus.op),
        .a      (bus.a),
        .b      (bus.b),
        .result (alu_result),
        .flags  (alu_flags),
        .known  (alu_known),
        .writes (alu_writes)
    );

    assign accept      = bus.in_valid && (state_reg == ST_IDLE) && !bus.flush;
    assign is_shift    = (bus.op == SHL) || (bus.op == SHR) || (bus.op == SAR);
    assign start_shift = is_shift && (bus.b[3:0] != 4'd0);
    assign start_mul   = (bus.op == MUL);

    // One iteration of the active multi-cycle op
    always_comb begin
        shift_val = work_reg;
        shift_c   = 1'b0;
        case (op_reg)
            SHL: begin
                shift_val = {work_reg[WIDTH-2:0], 1'b0};
                shift_c   = work_reg[WIDTH-1];
            end
            SHR: begin
                shift_val = {1'b0, work_reg[WIDTH-1:1]};
                shift_c   = work_reg[0];
            end
            SAR: begin
                shift_val = {work_reg[WIDTH-1], work_reg[WIDTH-1:1]};
                shift_c   = work_reg[0];
            end
            default: ;
        endcase
        mul_acc   = acc_reg + (work_reg[0] ? mcand_reg : '0);
        fin_res   = (state_reg == ST_SHIFT) ? shift_val : mul_acc;
        fin_c     = (state_reg == ST_SHIFT) ? shift_c : 1'b0;
        step_last = (state_reg != ST_IDLE) && !bus.flush && (cnt_reg == 5'd1);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept && start_shift)
                    state_next = ST_SHIFT;
                else if (accept && start_mul)
                    state_next = ST_MUL;
            end
            ST_SHIFT, ST_MUL: begin
                if (bus.flush || cnt_reg == 5'd1)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            op_reg    <= '0;
            dst_reg   <= '0;
            wb_en_reg <= 1'b0;
            cnt_reg   <= '0;
            work_reg  <= '0;
            mcand_reg <= '0;
            acc_reg   <= '0;
            we_reg    <= 1'b0;
            done_reg  <= 1'b0;
            src_w_reg <= '0;
            val_reg   <= '0;
            flags_reg <= '0;
        end else begin
            we_reg   <= 1'b0;
            done_reg <= 1'b0;
            if (accept) begin
                op_reg    <= bus.op;
                dst_reg   <= bus.dst;
                wb_en_reg <= bus.wb_en;
                if (start_shift) begin
                    work_reg <= bus.a;
                    cnt_reg  <= {1'b0, bus.b[3:0]};
                end else if (start_mul) begin
                    work_reg  <= bus.b;
                    mcand_reg <= bus.a;
                    acc_reg   <= '0;
                    cnt_reg   <= 5'd16;
                end else begin
                    done_reg <= 1'b1;
                    if (alu_known)
                        flags_reg <= alu_flags;
                    if (alu_known && alu_writes && bus.wb_en) begin
                        we_reg    <= 1'b1;
                        val_reg   <= alu_result;
                        src_w_reg <= bus.dst;
                    end
                end
            end
            // flush leaves the iteration state untouched; IDLE ignores it
            if (state_reg != ST_IDLE && !bus.flush) begin
                cnt_reg <= cnt_reg - 5'd1;
                if (state_reg == ST_SHIFT) begin
                    work_reg <= shift_val;
                end else begin
                    acc_reg   <= mul_acc;
                    mcand_reg <= {mcand_reg[WIDTH-2:0], 1'b0};
                    work_reg  <= {1'b0, work_reg[WIDTH-1:1]};
                end
            end
            if (step_last) begin
                done_reg              <= 1'b1;
                flags_reg[FLAG_N]     <= fin_res[WIDTH-1];
                flags_reg[FLAG_Z]     <= (fin_res == '0);
                flags_reg[FLAG_C]     <= fin_c;
                flags_reg[FLAG_V]     <= 1'b0;
                if (wb_en_reg) begin
                    we_reg    <= 1'b1;
                    val_reg   <= fin_res;
                    src_w_reg <= dst_reg;
                end
            end
        end
    end

    assign bus.in_ready = (state_reg == ST_IDLE);
    assign bus.we       = we_reg;
    assign bus.done     = done_reg;
    assign bus.src_w    = src_w_reg;
    assign bus.val      = val_reg;
    assign bus.flags    = flags_reg;
endmodule

// File: tb/tb_cpu_execute.sv
// ----------------------------------------------------------------------------
// tb_cpu_execute
// Directed bench for cpu_execute: reset values, single-cycle ALU ops and
// flags, back-to-back issue, SAR stall timing, MUL latency, flush in IDLE and
// mid-MUL, undefined op, and asynchronous reset in the middle of a shift.
// ----------------------------------------------------------------------------
module tb_cpu_execute;
    import exec_pkg::*;

    logic cpu_clk = 1'b0;
    logic cpu_rst = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   lat;
    int   pulses;

    always #5 cpu_clk = ~cpu_clk;

    cpu_execute_if #(.WIDTH(16), .REG_BITS(4)) bus ();

    cpu_execute #(.WIDTH(16), .REG_BITS(4)) dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .bus     (bus.slave)
    );

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv,
                         input logic [3:0] d, input logic w);
        bus.op       = o;
        bus.a        = av;
        bus.b        = bv;
        bus.dst      = d;
        bus.wb_en    = w;
        bus.in_valid = 1'b1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.op       = 4'd0;
        bus.a        = 16'h0;
        bus.b        = 16'h0;
        bus.dst      = 4'd0;
        bus.wb_en    = 1'b0;
        bus.flush    = 1'b0;

        // reset
        tick();
        tick();
        chk("rst_we", bus.we, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_src_w", bus.src_w, 0);
        chk("rst_val", bus.val, 0);
        chk("rst_flags", bus.flags, 0);
        cpu_rst = 1'b1;
        tick();
        chk("rst_ready", bus.in_ready, 1);

        // ADD with signed overflow
        issue(ADD, 16'h7FFF, 16'h0001, 4'd3, 1'b1);
        chk("add_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        chk("add_we", bus.we, 1);
        chk("add_done", bus.done, 1);
        chk("add_src_w", bus.src_w, 3);
        chk("add_val", bus.val, 16'h8000);
        chk("add_flags", bus.flags, 4'b1001);

        // CMP then SUB back-to-back
        issue(CMP, 16'd5, 16'd5, 4'd4, 1'b1);
        tick();
        issue(SUB, 16'd0, 16'd1, 4'd2, 1'b1);
        chk("cmp_ready", bus.in_ready, 1);
        chk("cmp_we", bus.we, 0);
        chk("cmp_done", bus.done, 1);
        chk("cmp_flags", bus.flags, 4'b0110);
        chk("cmp_val_hold", bus.val, 16'h8000);
        tick();
        bus.in_valid = 1'b0;
        chk("sub_we", bus.we, 1);
        chk("sub_val", bus.val, 16'hFFFF);
        chk("sub_src_w", bus.src_w, 2);
        chk("sub_flags", bus.flags, 4'b1000);

        // ADD with wb_en=0: carry out, zero result, flags only
        issue(ADD, 16'hFFFF, 16'h0001, 4'd1, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        chk("nowb_we", bus.we, 0);
        chk("nowb_done", bus.done, 1);
        chk("nowb_flags", bus.flags, 4'b0110);
        chk("nowb_val", bus.val, 16'hFFFF);

        // undefined op code
        issue(4'hC, 16'd1, 16'd2, 4'd1, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("undef_we", bus.we, 0);
        chk("undef_done", bus.done, 1);
        chk("undef_flags", bus.flags, 4'b0110);

        // SHL with zero count behaves as single-cycle
        issue(SHL, 16'h8001, 16'h0000, 4'd4, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("shl0_we", bus.we, 1);
        chk("shl0_val", bus.val, 16'h8001);
        chk("shl0_flags", bus.flags, 4'b1000);
        chk("shl0_ready", bus.in_ready, 1);

        // SAR by 3 with a held follow-on MOV
        issue(SAR, 16'h8004, 16'd3, 4'd5, 1'b1);
        tick();
        issue(MOV, 16'h0, 16'h1234, 4'd6, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("sar_ready_c%0d", i), bus.in_ready, 0);
            chk($sformatf("sar_done_c%0d", i), bus.done, 0);
            tick();
        end
        chk("sar_we", bus.we, 1);
        chk("sar_val", bus.val, 16'hF000);
        chk("sar_src_w", bus.src_w, 5);
        chk("sar_flags", bus.flags, 4'b1010);
        chk("sar_ready_back", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        chk("mov_we", bus.we, 1);
        chk("mov_val", bus.val, 16'h1234);
        chk("mov_src_w", bus.src_w, 6);
        chk("mov_flags", bus.flags, 4'b0000);

        // MUL 300*300, latency 17
        issue(MUL, 16'd300, 16'd300, 4'd7, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.we && lat < 40) begin
            tick();
            lat++;
        end
        chk("mul_latency", lat, 17);
        chk("mul_val", bus.val, 16'h5F90);
        chk("mul_src_w", bus.src_w, 7);
        chk("mul_flags", bus.flags, 4'b0000);
        chk("mul_ready", bus.in_ready, 1);

        // flush on cycle 5 of MUL
        issue(CMP, 16'd1, 16'd2, 4'd0, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("cmp2_flags", bus.flags, 4'b1000);
        issue(MUL, 16'd3, 16'd4, 4'd8, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_ready", bus.in_ready, 1);
        chk("flush_done", bus.done, 0);
        pulses = 0;
        repeat (20) begin
            if (bus.done) pulses++;
            tick();
        end
        chk("flush_no_pulse", pulses, 0);
        chk("flush_flags", bus.flags, 4'b1000);
        chk("flush_val", bus.val, 16'h5F90);

        // flush with in_valid in IDLE drops the op
        issue(MOV, 16'h0, 16'hABCD, 4'd9, 1'b1);
        bus.flush = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        chk("drop_done", bus.done, 0);
        tick();
        chk("drop_done2", bus.done, 0);
        chk("drop_val", bus.val, 16'h5F90);

        // flush while a single-cycle result is already asserting
        issue(MOV, 16'h0, 16'h0042, 4'd9, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        chk("late_flush_done", bus.done, 1);
        chk("late_flush_val", bus.val, 16'h0042);
        tick();
        bus.flush = 1'b0;

        // asynchronous reset in the middle of SHL by 15
        issue(CMP, 16'd1, 16'd2, 4'd0, 1'b1);
        tick();
        issue(SHL, 16'h0001, 16'd15, 4'd10, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        #2;
        cpu_rst = 1'b0;
        #1;
        chk("arst_we", bus.we, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_val", bus.val, 0);
        chk("arst_src_w", bus.src_w, 0);
        chk("arst_flags", bus.flags, 0);
        tick();
        cpu_rst = 1'b1;
        tick();
        chk("arst_ready", bus.in_ready, 1);
        pulses = 0;
        repeat (20) begin
            if (bus.we || bus.done) pulses++;
            tick();
        end
        chk("arst_no_wb", pulses, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_execute.md
Name: cpu_execute

Overview:
- Execute stage directly downstream of the register-read stage.
- Accepts a decoded op with two 16-bit operands and a destination register.
- Computes single-cycle ALU ops and iterative shift and multiply ops, updates the flags register, and drives the register-file write port (we, src_w, val).
- Stalls upstream through in_ready while a multi-cycle op is in flight.

Parameters:
- WIDTH, 16, datapath and register width.
- REG_BITS, 4, register index width.

Ports:
- cpu_clk  in  1  CPU clock; all state on rising edge.
- cpu_rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream presents an op.
- in_ready  out  1  stage can accept an op this cycle.
- op  in  4  operation code (exec_pkg::op_t).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; b[3:0] is the shift count for shifts.
- dst  in  REG_BITS  destination register.
- wb_en  in  1  write the result to dst (0 = flags only).
- flush  in  1  abort the in-flight op and drop the current input.
- we  out  1  register-file write strobe, one cycle per result.
- src_w  out  REG_BITS  register-file write index.
- val  out  WIDTH  register-file write data.
- done  out  1  one-cycle pulse per completed op, independent of wb_en.
- flags  out  4  {N,Z,C,V}, registered.

Behaviour:
- Reset (cpu_rst=0, async):
  - FSM goes to IDLE.
  - we=0, done=0, src_w=0, val=0, flags=4'b0000.
  - in_ready=1 once reset is released.
  - Reset mid-op discards the op with no writeback.
- Accept: in_valid & in_ready & ~flush. Operands, op, dst and wb_en are latched on accept.
- in_ready = (state==IDLE). This is combinational from state only, never from in_valid.
- FSM states: IDLE, SHIFT, MUL.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, NOT(a), MOV(b), CMP):
  - Result registered at the accept edge.
  - we/done assert the cycle after accept.
  - FSM stays IDLE, so back-to-back accepts give one result per cycle.
- Shifts (SHL, SHR, SAR), n = b[3:0]:
  - n=0 behaves as a single-cycle op; result = a, C=0.
  - n>0: IDLE->SHIFT. Shift one bit per cycle for n cycles, then SHIFT->IDLE.
  - we/done assert n+1 cycles after accept.
  - C = last bit shifted out.
- MUL:
  - IDLE->MUL, 16-iteration shift-add producing the low WIDTH bits.
  - we/done assert 17 cycles after accept, then MUL->IDLE.
  - C=V=0.
- we = done & wb_en_latched. val and src_w hold their last values when we=0.
- CMP computes SUB for flags only; we is forced to 0 regardless of wb_en.
- Flags update only on the done cycle:
  - Z = (result==0), N = result[WIDTH-1].
  - ADD: C = carry out, V = signed overflow.
  - SUB/CMP: computed as a + ~b + 1; C = carry out (1 means a>=b unsigned), V = signed overflow.
  - Logic ops and MOV: C=V=0.
  - SAR: V=0; SHL/SHR: V=0.
- Width: all arithmetic is modulo 2^WIDTH. The carry comes from a WIDTH+1-bit sum.
- flush:
  - In SHIFT or MUL, returns to IDLE next edge with no we/done and flags unchanged.
  - In IDLE, blocks the accept that cycle.
  - A registered single-cycle result whose done is already asserting still completes.
  - flush with in_valid in the same cycle: flush wins and the op is dropped.
- Undefined op codes complete in one cycle with no write (we=0), done=1, flags unchanged.

Decomposition:
- Package exec_pkg:
  - op_t enum: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, MOV=6, CMP=7, SHL=8, SHR=9, SAR=10, MUL=11.
  - state_t enum.
  - flag bit index constants FLAG_N, FLAG_Z, FLAG_C, FLAG_V.
- Sub-module cpu_alu: purely combinational single-cycle ops and flag generation.
- Iterative shift/MUL datapath and FSM stay in cpu_execute.

Test Plan:
- ADD a=16'h7FFF, b=16'h0001, dst=3, wb_en=1 -> next cycle: we=1, src_w=3, val=16'h8000, flags N=1 Z=0 C=0 V=1.
- CMP a=5, b=5, then SUB a=0, b=1, dst=2 back-to-back:
  - in_ready stays 1.
  - CMP: we=0, done=1, Z=1 C=1.
  - SUB: val=16'hFFFF, N=1 C=0.
- SAR a=16'h8004, b=3 -> in_ready=0 for 3 cycles; we 4 cycles after accept with val=16'hF000, C=1; in_valid held meanwhile is accepted the cycle in_ready returns to 1.
- MUL a=300, b=300 -> we exactly 17 cycles after accept, val=16'h5F90 (90000 mod 65536), C=V=0.
- flush asserted on cycle 5 of MUL -> no we/done pulse, flags unchanged, in_ready=1 next cycle; flush with in_valid in IDLE -> op dropped.
- cpu_rst driven low asynchronously mid-SHL (b=15) -> outputs and flags 0 immediately, no later writeback, in_ready=1 after release.
